// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte requesters, the UART transmit
// path and the arbiter. The arbiter uses the slave modport; whoever drives
// the requester and UART-ready side uses the master modport.
interface uart_tx_arbiter_if;
  logic       REQ0_WRITE_I;
  logic [7:0] REQ0_DATA_I;
  logic       REQ0_LOCK_I;
  logic       REQ0_READY_O;
  logic       REQ1_WRITE_I;
  logic [7:0] REQ1_DATA_I;
  logic       REQ1_LOCK_I;
  logic       REQ1_READY_O;
  logic       TX_READY_I;
  logic       TX_WRITE_O;
  logic [7:0] TX_DATA_O;
  logic [1:0] GRANT_O;
  logic       TIMEOUT_O;

  modport master (
    output REQ0_WRITE_I, REQ0_DATA_I, REQ0_LOCK_I,
    output REQ1_WRITE_I, REQ1_DATA_I, REQ1_LOCK_I,
    output TX_READY_I,
    input  REQ0_READY_O, REQ1_READY_O,
    input  TX_WRITE_O, TX_DATA_O, GRANT_O, TIMEOUT_O
  );

  modport slave (
    input  REQ0_WRITE_I, REQ0_DATA_I, REQ0_LOCK_I,
    input  REQ1_WRITE_I, REQ1_DATA_I, REQ1_LOCK_I,
    input  TX_READY_I,
    output REQ0_READY_O, REQ1_READY_O,
    output TX_WRITE_O, TX_DATA_O, GRANT_O, TIMEOUT_O
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte-transmit path between the debug
// TAP escape stream (req0) and a secondary raw channel (req1). A requester
// holding LOCK keeps the grant across a whole frame; a lock timeout forces
// release of a stalled owner and blocks its lock until LOCK is seen low.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               CLK_I,
  input  logic               RST_NI,
  uart_tx_arbiter_if.slave   bus
);

  // A zero timeout would give a zero-width counter; keep one bit that never moves.
  localparam int unsigned    CW       = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [CW-1:0]  CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_e;

  state_e        r_state, w_next;
  logic          r_rr;          // 0 favours req0, 1 favours req1
  logic          r_blk0, r_blk1;
  logic          r_tx_write, r_timeout;
  logic [7:0]    r_tx_data;
  logic [CW-1:0] r_cnt;

  logic       w_pend0, w_pend1, w_own;
  logic       w_own_write, w_own_lock;
  logic [7:0] w_own_data;
  logic       w_ready, w_xfer, w_inc, w_timeout, w_release;

  // A blocked lock does not count as a request; only a real byte does.
  assign w_pend0 = bus.REQ0_WRITE_I | (bus.REQ0_LOCK_I & ~r_blk0);
  assign w_pend1 = bus.REQ1_WRITE_I | (bus.REQ1_LOCK_I & ~r_blk1);
  assign w_own   = (r_state == S_OWN0) || (r_state == S_OWN1);

  // Select the current owner's request signals.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_own_write = 1'b0;
    w_own_lock  = 1'b0;
    w_own_data  = 8'h00;
    case (r_state)
      S_OWN0: begin
        w_own_write = bus.REQ0_WRITE_I;
        w_own_lock  = bus.REQ0_LOCK_I & ~r_blk0;
        w_own_data  = bus.REQ0_DATA_I;
      end
      S_OWN1: begin
        w_own_write = bus.REQ1_WRITE_I;
        w_own_lock  = bus.REQ1_LOCK_I & ~r_blk1;
        w_own_data  = bus.REQ1_DATA_I;
      end
      default: ;
    endcase
  end

  // UART ready lags our strobe by a cycle, so never accept right after a write.
  assign w_ready   = bus.TX_READY_I & ~r_tx_write;
  assign w_xfer    = w_own & w_own_write & w_ready;
  // Only an owner stalling under lock counts; UART backpressure does not.
  assign w_inc     = w_own & bus.TX_READY_I & ~w_xfer & w_own_lock;
  assign w_timeout = TO_EN && w_inc && (r_cnt == CNT_LAST);
  assign w_release = w_own & ((~w_own_lock & (w_xfer | ~w_own_write)) | w_timeout);

  // State register.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RST_NI) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: round-robin grant from IDLE, direct hand-over on release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pend0 && (!w_pend1 || !r_rr)) w_next = S_OWN0;
        else if (w_pend1)                  w_next = S_OWN1;
      end
      S_OWN0: if (w_release) w_next = w_pend1 ? S_OWN1 : S_IDLE;
      S_OWN1: if (w_release) w_next = w_pend0 ? S_OWN0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: grant and per-requester ready.
  always_comb begin
    bus.GRANT_O      = 2'b00;
    bus.REQ0_READY_O = 1'b0;
    bus.REQ1_READY_O = 1'b0;
    case (r_state)
      S_OWN0: begin
        bus.GRANT_O      = 2'b01;
        bus.REQ0_READY_O = w_ready;
      end
      S_OWN1: begin
        bus.GRANT_O      = 2'b10;
        bus.REQ1_READY_O = w_ready;
      end
      default: ;
    endcase
  end

  // Round-robin pointer flips to the other requester on every release.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)        r_rr <= 1'b0;
    else if (w_release) r_rr <= (r_state == S_OWN0);
  end

  // Lock-block flags: set on forced release, cleared once LOCK is seen low.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_blk0 <= 1'b0;
      r_blk1 <= 1'b0;
    end else begin
      if (w_timeout && r_state == S_OWN0) r_blk0 <= 1'b1;
      else if (!bus.REQ0_LOCK_I)          r_blk0 <= 1'b0;
      if (w_timeout && r_state == S_OWN1) r_blk1 <= 1'b1;
      else if (!bus.REQ1_LOCK_I)          r_blk1 <= 1'b0;
    end
  end

  // Timeout counter: cleared on any state change and on transfer, saturating.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)                                   r_cnt <= '0;
    else if (w_next != r_state || w_xfer)          r_cnt <= '0;
    else if (TO_EN && w_inc && r_cnt != CNT_MAX)   r_cnt <= r_cnt + CW'(1);
  end

  // UART strobe/data and timeout pulse, all registered one cycle after the event.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_tx_write <= 1'b0;
      r_tx_data  <= 8'h00;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_write <= w_xfer;
      r_timeout  <= w_timeout;
      if (w_xfer) r_tx_data <= w_own_data;
    end
  end

  assign bus.TX_WRITE_O = r_tx_write;
  assign bus.TX_DATA_O  = r_tx_data;
  assign bus.TIMEOUT_O  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte drivers, a
// scoreboard of expected UART bytes popped by a TX monitor, and directed
// scenarios for grant latency, round-robin, lock, backpressure, timeout and
// asynchronous reset.
module tb_uart_tx_arbiter;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK_I (clk),
    .RST_NI(rst_n),
    .bus   (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];
  int         n_tx  = 0;
  int         n_to  = 0;
  logic       prev_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() + q0.size() + q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size() + q0.size() + q1.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Requester 0 driver: present queue head, pop when accepted.
  initial begin : drv0
    logic acc;
    bus.REQ0_WRITE_I = 1'b0;
    bus.REQ0_DATA_I  = 8'h00;
    forever begin
      @(negedge clk);
      acc = bus.REQ0_WRITE_I && bus.REQ0_READY_O;
      @(posedge clk);
      #1;
      if (acc && rst_n && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        bus.REQ0_WRITE_I = 1'b1;
        bus.REQ0_DATA_I  = q0[0];
      end else begin
        bus.REQ0_WRITE_I = 1'b0;
      end
    end
  end

  // Requester 1 driver.
  initial begin : drv1
    logic acc;
    bus.REQ1_WRITE_I = 1'b0;
    bus.REQ1_DATA_I  = 8'h00;
    forever begin
      @(negedge clk);
      acc = bus.REQ1_WRITE_I && bus.REQ1_READY_O;
      @(posedge clk);
      #1;
      if (acc && rst_n && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        bus.REQ1_WRITE_I = 1'b1;
        bus.REQ1_DATA_I  = q1[0];
      end else begin
        bus.REQ1_WRITE_I = 1'b0;
      end
    end
  end

  // UART-side monitor: every strobe must match the scoreboard head and never be back-to-back.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (bus.TIMEOUT_O) n_to++;
      if (bus.TX_WRITE_O) begin
        n_tx++;
        check("tx_gap", prev_wr, 0);
        if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
        else                   check("tx_data", bus.TX_DATA_O, exp_q.pop_front());
      end
      prev_wr = bus.TX_WRITE_O;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin : main
    int         n;
    int         cnt;
    int         hi;
    int         bub;
    int         tx0;
    int         to0;
    logic       seen;
    logic [1:0] first;

    bus.REQ0_LOCK_I = 1'b0;
    bus.REQ1_LOCK_I = 1'b0;
    bus.TX_READY_I  = 1'b1;

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check("rst_grant",   bus.GRANT_O, 0);
    check("rst_txwr",    bus.TX_WRITE_O, 0);
    check("rst_txdata",  bus.TX_DATA_O, 0);
    check("rst_timeout", bus.TIMEOUT_O, 0);
    check("rst_rdy0",    bus.REQ0_READY_O, 0);
    check("rst_rdy1",    bus.REQ1_READY_O, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single requester, locked two-byte frame.
    step();
    bus.REQ0_LOCK_I = 1'b1;
    q0.push_back(8'hB1); q0.push_back(8'h05);
    exp_q.push_back(8'hB1); exp_q.push_back(8'h05);
    @(negedge clk);
    check("t1_pre_grant", bus.GRANT_O, 2'b00);
    @(negedge clk);
    check("t1_grant", bus.GRANT_O, 2'b01);
    hi = 0; n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.REQ1_READY_O) hi++;
    end
    check("t1_drain", exp_q.size(), 0);
    check("t1_rdy1_low", hi, 0);
    step();
    bus.REQ0_LOCK_I = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_idle", bus.GRANT_O, 2'b00);

    // Round-robin between unlocked continuous writers, fresh from reset.
    do_reset();
    step();
    q0.push_back(8'h10); q0.push_back(8'h11); q0.push_back(8'h12);
    q1.push_back(8'h20); q1.push_back(8'h21); q1.push_back(8'h22);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    exp_q.push_back(8'h12); exp_q.push_back(8'h22);
    n = 0; bub = 0; seen = 1'b0; first = 2'b00;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (!seen && bus.GRANT_O != 2'b00) begin
        seen  = 1'b1;
        first = bus.GRANT_O;
      end else if (seen && bus.GRANT_O == 2'b00 && (q0.size() + q1.size()) != 0) begin
        bub++;
      end
    end
    check("t2_drain", exp_q.size(), 0);
    check("t2_first", first, 2'b01);
    check("t2_bubbles", bub, 0);
    repeat (3) @(negedge clk);

    // Lock atomicity: four req0 bytes under lock before req1's 0xAA.
    step();
    bus.REQ0_LOCK_I = 1'b1;
    q0.push_back(8'hA0); q0.push_back(8'hA1); q0.push_back(8'hA2); q0.push_back(8'hA3);
    q1.push_back(8'hAA);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hAA);
    n = 0;
    while (q0.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("t3_q0_done", q0.size(), 0);
    bus.REQ0_LOCK_I = 1'b0;
    @(negedge clk);
    check("t3_hold", bus.GRANT_O, 2'b01);
    @(negedge clk);
    check("t3_switch", bus.GRANT_O, 2'b10);
    wait_drain("t3", 20);
    repeat (3) @(negedge clk);

    // Backpressure for 50 cycles during a locked req1 frame.
    step();
    bus.TX_READY_I  = 1'b0;
    bus.REQ1_LOCK_I = 1'b1;
    q1.push_back(8'hC0); q1.push_back(8'hC1); q1.push_back(8'hC2); q1.push_back(8'hC3);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    tx0 = n_tx; to0 = n_to;
    repeat (50) @(negedge clk);
    check("t4_grant", bus.GRANT_O, 2'b10);
    check("t4_no_tx", n_tx - tx0, 0);
    check("t4_no_to", n_to - to0, 0);
    step();
    bus.TX_READY_I = 1'b1;
    wait_drain("t4", 30);
    step();
    bus.REQ1_LOCK_I = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_to_after", n_to - to0, 0);
    check("t4_idle", bus.GRANT_O, 2'b00);

    // Timeout: req0 holds lock with nothing to send, req1 waiting.
    step();
    bus.REQ0_LOCK_I = 1'b1;
    q1.push_back(8'hD0);
    exp_q.push_back(8'hD0);
    n = 0;
    while (bus.GRANT_O != 2'b01 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("t5_grant0", bus.GRANT_O, 2'b01);
    cnt = 0;
    while (bus.GRANT_O == 2'b01 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_cycles", cnt, TO);
    check("t5_pulse", bus.TIMEOUT_O, 1);
    check("t5_grant1", bus.GRANT_O, 2'b10);
    @(negedge clk);
    check("t5_pulse_end", bus.TIMEOUT_O, 0);
    wait_drain("t5", 10);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.GRANT_O == 2'b01) hi++;
    end
    check("t5_blocked", hi, 0);
    step();
    bus.REQ0_LOCK_I = 1'b0;
    step();
    bus.REQ0_LOCK_I = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_regrant", bus.GRANT_O, 2'b01);
    step();
    bus.REQ0_LOCK_I = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-frame.
    step();
    bus.REQ0_LOCK_I = 1'b1;
    q0.push_back(8'hE0); q0.push_back(8'hE1);
    exp_q.push_back(8'hE0);
    n = 0;
    while (!(bus.GRANT_O == 2'b01 && bus.TX_WRITE_O) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_midframe", {bus.GRANT_O, bus.TX_WRITE_O}, 3'b011);
    #2;
    rst_n = 1'b0;
    q0.delete();
    bus.REQ0_LOCK_I = 1'b0;
    #1;
    check("t6_grant",   bus.GRANT_O, 0);
    check("t6_txwr",    bus.TX_WRITE_O, 0);
    check("t6_txdata",  bus.TX_DATA_O, 0);
    check("t6_timeout", bus.TIMEOUT_O, 0);
    check("t6_rdy0",    bus.REQ0_READY_O, 0);
    check("t6_sb",      exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    q0.push_back(8'hF0);
    q1.push_back(8'hF1);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hF1);
    n = 0;
    while (bus.GRANT_O == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_first", bus.GRANT_O, 2'b01);
    wait_drain("t6", 20);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte-transmit path (UART WE_I/DSEND_I/TX_READY_O) between two byte-stream requesters.
- Requester 0 is the TX_Escape output of the debug TAP; requester 1 is a secondary raw channel (e.g. STB console).
- Requesters hold a frame lock so that escape sequences and multi-byte frames are never interleaved.
- Arbitration is round-robin. A lock timeout stops a stalled owner from starving the other requester.

Parameters:
TIMEOUT_CYCLES, 1000000, number of idle owner cycles under lock before forced release; 0 disables the timeout.
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
CLK_I  in  1  system clock
RST_NI  in  1  reset; one clock; reset is asynchronous and active-low
REQ0_WRITE_I  in  1  requester 0 has a byte on REQ0_DATA_I
REQ0_DATA_I  in  8  requester 0 byte
REQ0_LOCK_I  in  1  requester 0 holds grant across bytes (frame in progress)
REQ0_READY_O  out  1  requester 0 byte accepted when high with REQ0_WRITE_I
REQ1_WRITE_I  in  1  as REQ0
REQ1_DATA_I  in  8  as REQ0
REQ1_LOCK_I  in  1  as REQ0
REQ1_READY_O  out  1  as REQ0
TX_READY_I  in  1  UART transmitter can take a byte
TX_WRITE_O  out  1  one-cycle write strobe to UART
TX_DATA_O  out  8  byte to UART
GRANT_O  out  2  one-hot current owner; 00 = idle
TIMEOUT_O  out  1  one-cycle pulse on forced release

Behaviour:
- Reset values: state IDLE; rr pointer favours req0; all outputs 0; counter 0; lock_block flags 0.
- A requester is pending when (WRITE_I | LOCK_I) and its lock_block flag is clear. A blocked requester is pending on WRITE_I alone.
- States: IDLE, OWN0, OWN1. GRANT_O equals 01 in OWN0, 10 in OWN1, 00 in IDLE.
- IDLE transitions:
  - If one requester is pending, move to its OWN state on the next cycle.
  - If both are pending, grant the requester the rr pointer favours.
  - Grant latency is 1 cycle from first pending; no byte is accepted in IDLE.
- Ready rules:
  - Owner READY_O = TX_READY_I & ~TX_WRITE_O. The second term blocks a double write while UART ready lags the strobe.
  - Non-owner READY_O = 0.
- Transfer: owner WRITE_I & READY_O. On transfer, register TX_DATA_O <= owner DATA_I and TX_WRITE_O <= 1 for exactly one cycle. Latency is 1 cycle. TX_DATA_O holds its value otherwise.
- Release:
  - Triggered at the end of an OWN cycle when owner LOCK_I=0 (or its lock is blocked) and either a transfer occurred or owner WRITE_I=0.
  - Unlocked requesters therefore send one byte per grant.
  - On release, the rr pointer favours the other requester.
  - If the other requester is pending, go directly to its OWN state (no IDLE bubble). Otherwise go to IDLE.
- Timeout counter:
  - Cleared on entry to OWN and on each transfer.
  - Increments in OWN when TX_READY_I=1, no transfer occurs and the owner is still held by lock. UART backpressure does not count.
  - When counter = TIMEOUT_CYCLES-1 and the increment condition is true:
    - force release as above;
    - pulse TIMEOUT_O for 1 cycle;
    - set the owner's lock_block flag.
  - lock_block clears when that requester's LOCK_I is seen low.
- TIMEOUT_CYCLES = 0: counter never runs, TIMEOUT_O is constant 0.
- Simultaneous release and new request from the same owner: the other requester wins if pending; otherwise the same owner is re-granted via IDLE.
- Owner drops WRITE_I mid-lock: nothing is sent, grant is held, the timeout counter runs.
- Reset mid-frame: state, counter and flags return to reset values immediately. Any registered but unissued byte is discarded; TX_WRITE_O = 0 during reset.
- Width rules: the counter saturates at its maximum and never wraps. All comparisons are unsigned.

Test Plan:
- Single requester: req0 writes 0xB1,0x05 with LOCK=1, TX_READY_I=1 -> GRANT_O=01 one cycle after request; TX_WRITE_O pulses at 2 non-adjacent cycles carrying 0xB1 then 0x05; REQ1_READY_O stays 0.
- Round-robin: both requesters unlocked, each writing continuously -> TX_DATA_O bytes alternate req0,req1,req0,...; first grant to req0 after reset; no IDLE cycles between grants.
- Lock atomicity: req0 frame of 4 bytes under LOCK while req1 writes 0xAA -> all 4 req0 bytes leave before 0xAA; GRANT_O switches to 10 the cycle after LOCK drops.
- Backpressure: TX_READY_I=0 for 50 cycles during a req1 frame with TIMEOUT_CYCLES=16 -> no timeout, no writes; transfers resume when TX_READY_I=1.
- Timeout: TIMEOUT_CYCLES=16, req0 LOCK=1 with WRITE_I=0, req1 pending -> TIMEOUT_O pulses after 16 idle cycles, GRANT_O becomes 10; req0 is not re-granted on LOCK alone until its LOCK_I is seen low.
- Async reset asserted mid-frame (GRANT_O=01, TX_WRITE_O=1) -> all outputs 0 immediately; after release, the first grant goes to req0.
